// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and imem handshake
//
// Purpose: holds the fetch PC, issues instruction memory requests, parks a
// fetched word while decode is stalled, and discards the in-flight response
// when a redirect arrives before the memory has answered.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stallF, stallD, flushD    hazard unit controls
//   pcsrcD, pcbranchD, jumpD  redirect sources resolved in decode
//   imem_req, imem_addr       fetch request / address (address equals pcF)
//   imem_ack, imem_rdata      memory response (ack may be combinational)
//   pcF                       fetch PC
//   instrD, pcplus4D, validD  IF/ID register contents
//   opD, functD               opcode and funct fields of instrD
//   imem_stallF               memory wait indication to the hazard unit
//
// Configuration: define FETCH_DELAY_SLOT_EN to deliver the sequential
// instruction fetched (or parked) during a redirect as a branch delay slot;
// otherwise that instruction becomes a bubble.

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        pcsrcD,
   input  logic [31:0] pcbranchD,
   input  logic        jumpD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pcF,
   output logic [31:0] instrD,
   output logic [31:0] pcplus4D,
   output logic [5:0]  opD,
   output logic [5:0]  functD,
   output logic        validD,
   output logic        imem_stallF
);

`ifdef FETCH_DELAY_SLOT_EN
   localparam logic DELAY_SLOT = 1'b1;
`else
   localparam logic DELAY_SLOT = 1'b0;
`endif

   typedef enum logic [1:0] {RUN, HOLD, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc4_q, hold_pc4_d;
   logic [31:0] tgt_q, tgt_d;

   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] target;

   assign pc_plus4 = pc_q + 32'd4;
   assign redirect = valid_q & ~stallD & (pcsrcD | jumpD);
   assign target   = pcsrcD ? pcbranchD : {pc4_q[31:28], instr_q[25:0], 2'b00};

   assign imem_req    = (state_q != HOLD);
   assign imem_addr   = pc_q;
   assign imem_stallF = imem_req & ~imem_ack;
   assign pcF         = pc_q;
   assign instrD      = instr_q;
   assign pcplus4D    = pc4_q;
   assign validD      = valid_q;
   assign opD         = instr_q[31:26];
   assign functD      = instr_q[5:0];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      tgt_d        = tgt_q;

      case (state_q)
         RUN: begin
            if (imem_ack) begin
               // A redirect takes precedence over a fetch stall.
               if (redirect)     pc_d = target;
               else if (!stallF) pc_d = pc_plus4;

               if (flushD) begin
                  instr_d = 32'h0;
                  valid_d = 1'b0;
               end else if (redirect) begin
                  // The word arriving now is the sequential (delay-slot) one.
                  if (DELAY_SLOT) begin
                     instr_d = imem_rdata;
                     pc4_d   = pc_plus4;
                     valid_d = 1'b1;
                  end else begin
                     instr_d = 32'h0;
                     valid_d = 1'b0;
                  end
               end else if (stallD) begin
                  hold_instr_d = imem_rdata;
                  hold_pc4_d   = pc_plus4;
                  state_d      = HOLD;
               end else begin
                  instr_d = imem_rdata;
                  pc4_d   = pc_plus4;
                  valid_d = 1'b1;
               end
            end else begin
               // Address must stay stable while the request is outstanding,
               // so a redirect is remembered and applied once the stale
               // response has been consumed.
               if (redirect) begin
                  tgt_d   = target;
                  state_d = DROP;
               end
               if (redirect || flushD) begin
                  instr_d = 32'h0;
                  valid_d = 1'b0;
               end
            end
         end

         HOLD: begin
            if (flushD) begin
               instr_d = 32'h0;
               valid_d = 1'b0;
               if (redirect) pc_d = target;
               state_d = RUN;
            end else if (redirect) begin
               pc_d = target;
               if (DELAY_SLOT) begin
                  instr_d = hold_instr_q;
                  pc4_d   = hold_pc4_q;
                  valid_d = 1'b1;
               end else begin
                  instr_d = 32'h0;
                  valid_d = 1'b0;
               end
               state_d = RUN;
            end else if (!stallD) begin
               instr_d = hold_instr_q;
               pc4_d   = hold_pc4_q;
               valid_d = 1'b1;
               state_d = RUN;
            end
         end

         DROP: begin
            if (flushD) begin
               instr_d = 32'h0;
               valid_d = 1'b0;
            end
            if (imem_ack) begin
               pc_d    = tgt_q;
               state_d = RUN;
            end
         end

         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         instr_q      <= 32'h0;
         pc4_q        <= 32'h0;
         valid_q      <= 1'b0;
         hold_instr_q <= 32'h0;
         hold_pc4_q   <= 32'h0;
         tgt_q        <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
         tgt_q        <= tgt_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0;
   logic        pcsrcD = 1'b0, jumpD = 1'b0;
   logic [31:0] pcbranchD = 32'h0;
   logic        imem_req, imem_ack, imem_stallF, validD;
   logic [31:0] imem_addr, imem_rdata, pcF, instrD, pcplus4D;
   logic [5:0]  opD, functD;
   logic        ack_gate = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h0800_0020;
      return {6'h23, 10'h0, a[15:0]};
   endfunction

   assign imem_ack   = imem_req & ack_gate;
   assign imem_rdata = mem(imem_addr);

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .jumpD(jumpD),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D),
      .opD(opD), .functD(functD), .validD(validD), .imem_stallF(imem_stallF)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      stallF = 0; stallD = 0; flushD = 0; pcsrcD = 0; jumpD = 0;
      pcbranchD = 32'h0; ack_gate = 1;
      rst = 1;
      step();
      rst = 0;
      #1;
   endtask

   task automatic test_reset();
      stallF = 0; stallD = 0; flushD = 0; pcsrcD = 0; jumpD = 0; ack_gate = 1;
      rst = 1;
      step(); step();
      checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pcF, 32'h0); end
      checks++; if (validD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", validD); end
      checks++; if (instrD !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instrD); end
      checks++; if (pcplus4D !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 0", pcplus4D); end
      rst = 0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0: got %h expected 0", imem_addr); end
      step();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr4: got %h expected 4", imem_addr); end
      checks++; if (validD !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b expected 1", validD); end
      checks++; if (instrD !== 32'h8C00_0000) begin errors++; $display("FAIL seq_instr0: got %h expected 8c000000", instrD); end
      checks++; if (opD !== 6'h23) begin errors++; $display("FAIL seq_op: got %h expected 23", opD); end
      checks++; if (pcplus4D !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h expected 4", pcplus4D); end
      step();
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr8: got %h expected 8", imem_addr); end
      checks++; if (instrD !== 32'h8C00_0004) begin errors++; $display("FAIL seq_instr4: got %h expected 8c000004", instrD); end
      checks++; if (functD !== 6'h04) begin errors++; $display("FAIL seq_funct: got %h expected 04", functD); end
   endtask

   task automatic test_branch();
      do_reset();
      repeat (5) step();
      checks++; if (instrD !== 32'h8C00_0010) begin errors++; $display("FAIL br_setup: got %h expected 8c000010", instrD); end
      pcsrcD = 1; pcbranchD = 32'h40;
      step();
      pcsrcD = 0; #1;
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr: got %h expected 40", imem_addr); end
`ifdef FETCH_DELAY_SLOT_EN
      checks++; if (validD !== 1'b1) begin errors++; $display("FAIL br_slot_valid: got %b expected 1", validD); end
      checks++; if (instrD !== 32'h8C00_0014) begin errors++; $display("FAIL br_slot_instr: got %h expected 8c000014", instrD); end
`else
      checks++; if (validD !== 1'b0) begin errors++; $display("FAIL br_slot_valid: got %b expected 0", validD); end
      checks++; if (instrD !== 32'h0) begin errors++; $display("FAIL br_slot_instr: got %h expected 0", instrD); end
`endif
      step();
      checks++; if (instrD !== 32'h8C00_0040) begin errors++; $display("FAIL br_target_instr: got %h expected 8c000040", instrD); end
      checks++; if (pcplus4D !== 32'h44) begin errors++; $display("FAIL br_target_pc4: got %h expected 44", pcplus4D); end
   endtask

   task automatic test_imem_wait();
      do_reset();
      step(); step();
      ack_gate = 0; #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_stallF !== 1'b1) begin errors++; $display("FAIL wait_stall%0d: got %b expected 1", i, imem_stallF); end
         checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL wait_addr%0d: got %h expected 8", i, imem_addr); end
         checks++; if (instrD !== 32'h8C00_0004 || validD !== 1'b1) begin errors++; $display("FAIL wait_ifid%0d: got %h/%b expected 8c000004/1", i, instrD, validD); end
         step();
      end
      ack_gate = 1; #1;
      checks++; if (imem_stallF !== 1'b0) begin errors++; $display("FAIL wait_release: got %b expected 0", imem_stallF); end
      step();
      checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL wait_next_addr: got %h expected c", imem_addr); end
      checks++; if (instrD !== 32'h8C00_0008) begin errors++; $display("FAIL wait_next_instr: got %h expected 8c000008", instrD); end
   endtask

   task automatic test_jump_drop();
      do_reset();
      step();
      pcsrcD = 1; pcbranchD = 32'h1000;
      step();
      pcsrcD = 0;
      step();
      checks++; if (instrD !== 32'h0800_0020 || pcplus4D !== 32'h1004) begin errors++; $display("FAIL jmp_setup: got %h/%h expected 08000020/1004", instrD, pcplus4D); end
      ack_gate = 0; jumpD = 1; #1;
      checks++; if (imem_stallF !== 1'b1) begin errors++; $display("FAIL jmp_pending: got %b expected 1", imem_stallF); end
      step();
      jumpD = 0; #1;
      checks++; if (validD !== 1'b0) begin errors++; $display("FAIL jmp_bubble: got %b expected 0", validD); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1004) begin errors++; $display("FAIL jmp_drop_addr: got %b/%h expected 1/1004", imem_req, imem_addr); end
      step();
      ack_gate = 1; #1;
      step();
      checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL jmp_target: got %h expected 80", imem_addr); end
      checks++; if (validD !== 1'b0) begin errors++; $display("FAIL jmp_discard: got %b expected 0", validD); end
      step();
      checks++; if (instrD !== 32'h8C00_0080 || validD !== 1'b1) begin errors++; $display("FAIL jmp_first: got %h/%b expected 8c000080/1", instrD, validD); end
   endtask

   task automatic test_hold();
      do_reset();
      repeat (8) step();
      checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL hold_setup: got %h expected 20", imem_addr); end
      stallD = 1;
      step();
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h24) begin errors++; $display("FAIL hold_park: got %b/%h expected 0/24", imem_req, imem_addr); end
      checks++; if (instrD !== 32'h8C00_001C) begin errors++; $display("FAIL hold_ifid: got %h expected 8c00001c", instrD); end
      step();
      stallD = 0; #1;
      checks++; if (imem_req !== 1'b0 || instrD !== 32'h8C00_001C) begin errors++; $display("FAIL hold_still: got %b/%h expected 0/8c00001c", imem_req, instrD); end
      step();
      checks++; if (instrD !== 32'h8C00_0020 || pcplus4D !== 32'h24 || validD !== 1'b1) begin errors++; $display("FAIL hold_release: got %h/%h/%b expected 8c000020/24/1", instrD, pcplus4D, validD); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin errors++; $display("FAIL hold_resume: got %b/%h expected 1/24", imem_req, imem_addr); end
      step();
      checks++; if (instrD !== 32'h8C00_0024 || imem_addr !== 32'h28) begin errors++; $display("FAIL hold_next: got %h/%h expected 8c000024/28", instrD, imem_addr); end
   endtask

   task automatic test_flush();
      do_reset();
      repeat (3) step();
      flushD = 1;
      step();
      flushD = 0; #1;
      checks++; if (validD !== 1'b0 || instrD !== 32'h0) begin errors++; $display("FAIL flush_bubble: got %h/%b expected 0/0", instrD, validD); end
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL flush_pc: got %h expected 10", imem_addr); end
      step();
      checks++; if (instrD !== 32'h8C00_0010 || validD !== 1'b1) begin errors++; $display("FAIL flush_after: got %h/%b expected 8c000010/1", instrD, validD); end
   endtask

   task automatic test_wrap();
      do_reset();
      step();
      pcsrcD = 1; pcbranchD = 32'hFFFF_FFFC;
      step();
      pcsrcD = 0; #1;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected fffffffc", imem_addr); end
      step();
      checks++; if (imem_addr !== 32'h0 || pcplus4D !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h/%h expected 0/0", imem_addr, pcplus4D); end
      checks++; if (instrD !== 32'h8C00_FFFC) begin errors++; $display("FAIL wrap_instr: got %h expected 8c00fffc", instrD); end
   endtask

   task automatic test_reset_in_drop();
      do_reset();
      step();
      ack_gate = 0; pcsrcD = 1; pcbranchD = 32'h40; #1;
      step();
      pcsrcD = 0; #1;
      checks++; if (validD !== 1'b0 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL rdrop_setup: got %b/%h/%b expected 0/4/1", validD, imem_addr, imem_req); end
      rst = 1;
      step();
      rst = 0; ack_gate = 1; #1;
      checks++; if (pcF !== 32'h0 || validD !== 1'b0) begin errors++; $display("FAIL rdrop_reset: got %h/%b expected 0/0", pcF, validD); end
      step();
      checks++; if (pcF !== 32'h4 || instrD !== 32'h8C00_0000) begin errors++; $display("FAIL rdrop_after: got %h/%h expected 4/8c000000", pcF, instrD); end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_imem_wait();
      test_jump_drop();
      test_hold();
      test_flush();
      test_wrap();
      test_reset_in_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
